// File: rtl/config_pkg.sv
// Minimal core-configuration package: the configuration record handed down
// from the core top, plus the empty configuration used as a parameter default.
package config_pkg;

    typedef struct packed {
        logic [31:0] XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd0};

endpackage

// File: rtl/decode_issue_queue_pkg.sv
// Shared constants and sizing helpers for the decode-to-issue queue.
package decode_issue_queue_pkg;

    localparam int unsigned INSTR_W = 32;

    // Occupancy must represent DEPTH itself, hence one bit beyond the pointer.
    function automatic int unsigned dq_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/decode_issue_queue.sv
// Decoded-instruction FIFO between ID and issue: buffers up to DEPTH decoded
// entries and presents the oldest one to the issue stage as valid/ack.
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type scoreboard_entry_t = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               dec_valid_i,
    output logic                               dec_ready_o,
    input  scoreboard_entry_t                  dec_entry_i,
    input  logic [INSTR_W-1:0]                 dec_orig_instr_i,
    input  logic                               dec_is_ctrl_flow_i,
    output logic                               issue_valid_o,
    output scoreboard_entry_t                  issue_entry_o,
    output logic [INSTR_W-1:0]                 issue_orig_instr_o,
    output logic                               issue_is_ctrl_flow_o,
    input  logic                               issue_ack_i,
    output logic [dq_cnt_width(DEPTH)-1:0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = dq_cnt_width(DEPTH);

    typedef struct packed {
        scoreboard_entry_t    entry;
        logic [INSTR_W-1:0]   orig_instr;
        logic                 ctrl_flow;
    } slot_t;

    // No configuration field changes this queue; it is carried for parity with the issue stage.
    if (CVA6Cfg.XLEN != 32'd0) begin : g_cfg_present
    end

    slot_t           mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;

    // Readiness comes only from registered occupancy, so a full queue refuses a push even while popping.
    assign full_s  = (count_q == CntW'(DEPTH));
    assign empty_s = (count_q == {CntW{1'b0}});
    assign push_s  = dec_valid_i & ~full_s & ~flush_i;
    assign pop_s   = ~empty_s & issue_ack_i & ~flush_i;

    assign dec_ready_o          = ~full_s;
    assign issue_valid_o        = ~empty_s;
    assign issue_entry_o        = mem_q[rd_ptr_q].entry;
    assign issue_orig_instr_o   = mem_q[rd_ptr_q].orig_instr;
    assign issue_is_ctrl_flow_o = mem_q[rd_ptr_q].ctrl_flow;
    assign count_o              = count_q;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = {PtrW{1'b0}};
            wr_ptr_d = {PtrW{1'b0}};
            count_d  = {CntW{1'b0}};
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= {PtrW{1'b0}};
            wr_ptr_q <= {PtrW{1'b0}};
            count_q  <= {CntW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately unreset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= '{entry:      dec_entry_i,
                                 orig_instr: dec_orig_instr_i,
                                 ctrl_flow:  dec_is_ctrl_flow_i};
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed vector table, a
// streaming push+ack run, randomized traffic and a mid-operation reset.
module tb_decode_issue_queue;

    localparam int unsigned DEPTH = 2;

    typedef logic [7:0] entry_t;

    typedef struct {
        entry_t      e;
        logic [31:0] o;
        logic        c;
    } item_t;

    typedef struct {
        logic        fl;
        logic        dv;
        logic [31:0] orig;
        logic        ack;
        logic        x_valid;
        logic        x_ready;
        int          x_count;
        logic [31:0] x_head;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    entry_t      dec_entry;
    logic [31:0] dec_orig;
    logic        dec_cf;
    logic        iss_valid;
    entry_t      iss_entry;
    logic [31:0] iss_orig;
    logic        iss_cf;
    logic        iss_ack;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    item_t mq[$];

    decode_issue_queue #(
        .scoreboard_entry_t(entry_t),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .dec_valid_i(dec_valid),
        .dec_ready_o(dec_ready),
        .dec_entry_i(dec_entry),
        .dec_orig_instr_i(dec_orig),
        .dec_is_ctrl_flow_i(dec_cf),
        .issue_valid_o(iss_valid),
        .issue_entry_o(iss_entry),
        .issue_orig_instr_o(iss_orig),
        .issue_is_ctrl_flow_o(iss_cf),
        .issue_ack_i(iss_ack),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Entry and control-flow flag are derived from the raw word so each offer is distinct.
    task automatic drive(input logic fl, input logic dv, input logic [31:0] orig, input logic ack);
        flush     = fl;
        dec_valid = dv;
        dec_orig  = orig;
        dec_entry = orig[7:0] ^ orig[15:8] ^ 8'h5A;
        dec_cf    = orig[2];
        iss_ack   = ack;
    endtask

    task automatic sample_and_check();
        @(negedge clk);
        chk("valid", 32'(iss_valid), 32'(mq.size() != 0));
        chk("ready", 32'(dec_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_orig", iss_orig, mq[0].o);
            chk("head_entry", 32'(iss_entry), 32'(mq[0].e));
            chk("head_cf", 32'(iss_cf), 32'(mq[0].c));
        end
    endtask

    // Reference queue update from the handshake rules, applied at the clock edge.
    task automatic advance();
        item_t it;
        bit    do_push;
        bit    do_pop;
        do_push = dec_valid && (mq.size() < DEPTH) && !flush;
        do_pop  = (mq.size() != 0) && iss_ack && !flush;
        it.e = dec_entry;
        it.o = dec_orig;
        it.c = dec_cf;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        chk("reset_valid", 32'(iss_valid), 32'd0);
        chk("reset_ready", 32'(dec_ready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //            fl    dv    orig          ack   v     r     cnt head
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1, 32'h00000013});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 1, 32'h11111111});
        vt.push_back('{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 2, 32'h11111111});
        vt.push_back('{1'b0, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, 2, 32'h11111111});
        vt.push_back('{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1, 32'h22222222});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2, 32'h22222222});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1, 32'h33333333});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 1'b1, 1, 32'h44444444});
        vt.push_back('{1'b1, 1'b1, 32'h66666666, 1'b1, 1'b1, 1'b0, 2, 32'h44444444});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b1, 0, 32'h0});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1, 32'h77777777});
        vt.push_back('{1'b0, 1'b1, 32'h88888888, 1'b1, 1'b1, 1'b1, 1, 32'h77777777});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1, 32'h88888888});
        vt.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h0});

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].fl, vt[i].dv, vt[i].orig, vt[i].ack);
            sample_and_check();
            chk($sformatf("vec%0d_valid", i), 32'(iss_valid), 32'(vt[i].x_valid));
            chk($sformatf("vec%0d_ready", i), 32'(dec_ready), 32'(vt[i].x_ready));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].x_count));
            if (vt[i].x_valid) chk($sformatf("vec%0d_head", i), iss_orig, vt[i].x_head);
            advance();
        end

        // Streaming: one push then 100 cycles of push+ack must hold occupancy at one.
        drive(1'b0, 1'b1, $urandom, 1'b0);
        sample_and_check();
        advance();
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, $urandom, 1'b1);
            sample_and_check();
            chk("stream_count", 32'(count), 32'd1);
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        sample_and_check();
        advance();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 2) != 0));
            sample_and_check();
            advance();
        end

        // Fill, then reset asynchronously between edges; everything buffered is lost.
        drive(1'b0, 1'b1, 32'hAAAA0001, 1'b0);
        sample_and_check();
        advance();
        drive(1'b0, 1'b1, 32'hAAAA0002, 1'b0);
        sample_and_check();
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("async_rst_valid", 32'(iss_valid), 32'd0);
        chk("async_rst_ready", 32'(dec_ready), 32'd1);
        chk("async_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'hBEEF0013, 1'b0);
        sample_and_check();
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        sample_and_check();
        chk("post_rst_head", iss_orig, 32'hBEEF0013);
        advance();
        sample_and_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
